data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Shares the single-port 4K x 16 data memory between two requesters: port 0 (processor core load/store) and port 1 (external I/O / loader channel).
- Port 0 has fixed priority.
- A starvation counter forces port 1 through after a bounded number of denied cycles.
- Sits between the core and the data memory instance, driving its address, write-enable and write-data pins and returning read data with a valid strobe.

Parameters:
ADDR_W, 12, word address width of data memory
DATA_W, 16, data width
STARVE_LIMIT, 4, consecutive denied cycles of port 1 after which port 1 wins the next contested cycle (legal range 1..15)

Ports:
CLK  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  port 0 access request; held until gnt0
we0  input  1  port 0 write (1) / read (0)
addr0  input  ADDR_W  port 0 word address
wdata0  input  DATA_W  port 0 write data
gnt0  output  1  port 0 accepted this cycle (combinational)
rvalid0  output  1  port 0 read data valid
req1, we1, addr1, wdata1, gnt1, rvalid1  as port 0, for port 1
rdata  output  DATA_W  read data, shared by both ports, qualified by rvalid0/rvalid1
mem_addr  output  ADDR_W  to memory address pin
mem_we  output  1  to memory write enable
mem_din  output  DATA_W  to memory write data
mem_dout  input  DATA_W  from memory read data (1-cycle latency)
conflict_count  output  16  contested-cycle counter (see Optional Feature)

Behaviour:
- Arbitration is combinational within a cycle: at most one of gnt0/gnt1 is high. The winner's addr/we/wdata drive mem_*, and the memory samples them on the next rising edge.
- Win rules:
  - Only req0: port 0 wins.
  - Only req1: port 1 wins.
  - Both: port 0 wins unless starve_cnt == STARVE_LIMIT, in which case port 1 wins.
- starve_cnt (4-bit register):
  - Increments when req1 is high and gnt1 is low.
  - Clears to 0 on gnt1 or when req1 is low.
  - Saturates at STARVE_LIMIT.
- No winner: mem_we=0; mem_addr holds the last driven address (registered copy); mem_din don't-care.
- Read latency:
  - A read granted in cycle N (gnt=1, we=0) sets the matching rvalid for exactly cycle N+1.
  - rdata = mem_dout, combinational pass-through.
  - Writes never raise rvalid.
- Back-to-back grants are allowed. A read at N followed by any access at N+1 still returns rvalid at N+1 for the first read.
- Read-after-write to the same address in consecutive grants returns the new data; memory is write-first, and the arbiter adds no forwarding.
- While reset is high, regardless of requests:
  - gnt0=gnt1=0, mem_we=0, rvalid0=rvalid1=0.
  - starve_cnt=0, mem_addr register=0, conflict_count=0.
- Reset mid-operation: a read granted in the cycle before reset asserts does not produce rvalid. Reset clears the pending-valid flags.
- A requester dropping req without a grant is legal; no state is retained for it except that starve_cnt clears.

Optional Feature:
Macro DATA_MEM_ARBITER_STATS_EN.
- Defined:
  - conflict_count is a 16-bit register that increments on every cycle with req0 & req1 both high.
  - Wraps 0xFFFF -> 0x0000; cleared by reset.
- Undefined: conflict_count is tied to 0 and no counter logic is generated. Arbitration behaviour is identical in both builds.

Test Plan:
- Single read port 0: mem preloaded [0x010]=0xBEEF; req0=1, we0=0, addr0=0x010 for one cycle -> gnt0=1 same cycle, rvalid0=1 next cycle with rdata=0xBEEF, rvalid1 stays 0.
- Write then read port 1: write 0x1234 to 0x0A5, then read 0x0A5 -> gnt1 both cycles, no rvalid on write, rvalid1=1 with rdata=0x1234 one cycle after the read grant.
- Starvation, STARVE_LIMIT=4: req0 and req1 held high continuously -> gnt0 for 4 cycles, gnt1 on cycle 5, gnt0 cycles 6-9, gnt1 cycle 10; never both grants high.
- Reset mid-read: port 0 read granted at cycle N, reset=1 at N+1 -> rvalid0=0 at N+1; all grants 0 during reset; starve_cnt restarts from 0 afterwards.
- Idle: no requests for 3 cycles after a write to 0x7FF -> mem_we=0, mem_addr=0x7FF held, no grants or rvalids.
- Stats (macro defined): 10 contested cycles -> conflict_count=10; with counter preset near wrap via 0x10000 contested cycles -> reads 0; macro undefined -> conflict_count=0 throughout.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the shared 4K x 16 data memory. Port 0 has fixed priority and port 1 is forced through after STARVE_LIMIT denials.
// Grants are combinational, rvalid follows a read grant by one cycle, and a losing port simply holds req. Optional macro: DATA_MEM_ARBITER_STATS_EN.
module data_mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       conflict_count
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              starve_hit;

  always_comb begin
    starve_hit   = (starve_cnt_q == LIMIT);
    gnt0         = !reset && req0 && !(req1 && starve_hit);
    gnt1         = !reset && req1 && (!req0 || starve_hit);
    mem_addr_d   = mem_addr_q;
    mem_we       = 1'b0;
    mem_din      = wdata0;
    rvalid0_d    = gnt0 && !we0;
    rvalid1_d    = gnt1 && !we1;
    starve_cnt_d = starve_cnt_q;

    if (gnt0) begin
      mem_addr_d = addr0;
      mem_we     = we0;
    end else if (gnt1) begin
      mem_addr_d = addr1;
      mem_we     = we1;
      mem_din    = wdata1;
    end
    // With no winner the address pin parks on the last address actually driven.
    mem_addr = (gnt0 || gnt1) ? mem_addr_d : mem_addr_q;

    if (!req1 || gnt1) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      mem_addr_q   <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // Gating with reset drops a read that was granted just before reset rose.
  assign rvalid0 = rvalid0_q && !reset;
  assign rvalid1 = rvalid1_q && !reset;
  assign rdata   = mem_dout;

`ifdef DATA_MEM_ARBITER_STATS_EN
  logic [15:0] conflict_count_q, conflict_count_d;

  always_comb begin
    conflict_count_d = conflict_count_q;
    if (req0 && req1) begin
      conflict_count_d = conflict_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      conflict_count_q <= 16'd0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign conflict_count = conflict_count_q;
`else
  assign conflict_count = 16'd0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a write-first, 1-cycle-latency memory model.
module tb_data_mem_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [15:0] conflict_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] mem [0:4095];

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      mem_dout      <= mem_din;
    end else begin
      mem_dout <= mem[mem_addr];
    end
  end

  data_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .conflict_count(conflict_count)
  );

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = 12'h000; wdata0 = 16'h0000;
    req1 = 1'b0; we1 = 1'b0; addr1 = 12'h000; wdata1 = 16'h0000;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    tests_run++; if (gnt0 !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
    tests_run++; if (gnt1 !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    tests_run++; if ({rvalid0, rvalid1} !== 2'b00) begin tests_failed++; $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1}); end
    tests_run++; if (mem_addr !== 12'h000) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    tests_run++; if (conflict_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_conflict: got %h want 0000", conflict_count); end
    @(negedge CLK);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_read_p0();
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h010; wdata0 = 16'hBEEF;
    #1;
    tests_run++; if ({gnt0, gnt1, mem_we} !== 3'b101) begin tests_failed++; $display("FAIL p0_write_gnt: got %b want 101", {gnt0, gnt1, mem_we}); end
    @(negedge CLK);
    tests_run++; if (rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL p0_write_no_rvalid: got %b want 0", rvalid0); end
    we0 = 1'b0;
    #1;
    tests_run++; if ({gnt0, mem_we, mem_addr} !== {2'b10, 12'h010}) begin tests_failed++; $display("FAIL p0_read_gnt: got %b %b %h want 1 0 010", gnt0, mem_we, mem_addr); end
    @(negedge CLK);
    req0 = 1'b0;
    tests_run++; if ({rvalid0, rvalid1} !== 2'b10) begin tests_failed++; $display("FAIL p0_read_rvalid: got %b want 10", {rvalid0, rvalid1}); end
    tests_run++; if (rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL p0_read_data: got %h want beef", rdata); end
    @(negedge CLK);
    tests_run++; if (rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL p0_rvalid_one_cycle: got %b want 0", rvalid0); end
  endtask

  task automatic test_write_read_p1();
    @(negedge CLK);
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0A5; wdata1 = 16'h1234;
    #1;
    tests_run++; if ({gnt0, gnt1, mem_we, mem_din} !== {3'b011, 16'h1234}) begin tests_failed++; $display("FAIL p1_write_gnt: got %b%b%b %h want 011 1234", gnt0, gnt1, mem_we, mem_din); end
    @(negedge CLK);
    tests_run++; if (rvalid1 !== 1'b0) begin tests_failed++; $display("FAIL p1_write_no_rvalid: got %b want 0", rvalid1); end
    we1 = 1'b0;
    #1;
    tests_run++; if ({gnt1, mem_we} !== 2'b10) begin tests_failed++; $display("FAIL p1_read_gnt: got %b want 10", {gnt1, mem_we}); end
    @(negedge CLK);
    req1 = 1'b0;
    tests_run++; if ({rvalid0, rvalid1, rdata} !== {2'b01, 16'h1234}) begin tests_failed++; $display("FAIL p1_read_data: got %b %h want 01 1234", {rvalid0, rvalid1}, rdata); end
  endtask

  task automatic test_starvation();
    logic exp1;
    @(negedge CLK);
    req0 = 1'b1; addr0 = 12'h001; req1 = 1'b1; addr1 = 12'h002;
    for (int c = 1; c <= 10; c++) begin
      #1;
      exp1 = (c == 5) || (c == 10);
      tests_run++; if ({gnt0, gnt1} !== {!exp1, exp1}) begin tests_failed++; $display("FAIL starve_cycle%0d: got %b%b want %b%b", c, gnt0, gnt1, !exp1, exp1); end
      @(negedge CLK);
    end
    // Three denials, then req1 drops: the count must restart from zero.
    repeat (3) @(negedge CLK);
    req1 = 1'b0;
    @(negedge CLK);
    req1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      exp1 = (c == 5);
      tests_run++; if ({gnt0, gnt1} !== {!exp1, exp1}) begin tests_failed++; $display("FAIL starve_clear_cycle%0d: got %b%b want %b%b", c, gnt0, gnt1, !exp1, exp1); end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    #1;
    tests_run++; if (gnt0 !== 1'b1) begin tests_failed++; $display("FAIL midrst_gnt: got %b want 1", gnt0); end
    @(negedge CLK);
    reset = 1'b1; req1 = 1'b1;
    #1;
    tests_run++; if ({gnt0, gnt1, rvalid0, rvalid1, mem_we} !== 5'b00000) begin tests_failed++; $display("FAIL midrst_outputs: got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, mem_we}); end
    @(negedge CLK);
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      tests_run++; if (gnt1 !== (c == 5)) begin tests_failed++; $display("FAIL midrst_starve_cycle%0d: got gnt1=%b want %b", c, gnt1, (c == 5)); end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  task automatic test_idle();
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h7FF; wdata0 = 16'h5A5A;
    @(negedge CLK);
    idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      #1;
      tests_run++; if ({mem_we, gnt0, gnt1, rvalid0, rvalid1} !== 5'b00000 || mem_addr !== 12'h7FF) begin tests_failed++; $display("FAIL idle_cycle%0d: got %b addr %h want 00000 addr 7ff", c, {mem_we, gnt0, gnt1, rvalid0, rvalid1}, mem_addr); end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h100; wdata0 = 16'hAAAA;
    @(negedge CLK);
    we0 = 1'b0;
    @(negedge CLK);
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 12'h7FF;
    #1;
    tests_run++; if ({gnt1, rvalid0, rvalid1, rdata} !== {3'b110, 16'hAAAA}) begin tests_failed++; $display("FAIL b2b_raw: got %b%b%b %h want 110 aaaa", gnt1, rvalid0, rvalid1, rdata); end
    @(negedge CLK);
    req1 = 1'b0;
    tests_run++; if ({rvalid0, rvalid1, rdata} !== {2'b01, 16'h5A5A}) begin tests_failed++; $display("FAIL b2b_p1_read: got %b%b %h want 01 5a5a", rvalid0, rvalid1, rdata); end
    idle_inputs();
  endtask

  task automatic test_stats();
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    repeat (10) @(negedge CLK);
`ifdef DATA_MEM_ARBITER_STATS_EN
    tests_run++; if (conflict_count !== 16'd10) begin tests_failed++; $display("FAIL stats_ten: got %0d want 10", conflict_count); end
    repeat (65536 - 10) @(negedge CLK);
    tests_run++; if (conflict_count !== 16'd0) begin tests_failed++; $display("FAIL stats_wrap: got %0d want 0", conflict_count); end
`else
    tests_run++; if (conflict_count !== 16'd0) begin tests_failed++; $display("FAIL stats_disabled: got %0d want 0", conflict_count); end
`endif
    idle_inputs();
    @(negedge CLK);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read_p0();
    test_write_read_p1();
    test_starvation();
    test_reset_mid_read();
    test_idle();
    test_back_to_back();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
